ppwm_seq_ctrl: RTL and testbench

- Sequencer and configuration controller for one PWM execution core.
- Owns the instruction store, the prescaled global counter and the period-start pulse.
- Gates the core's synchronous reset, so the core only runs once a program has been loaded and the block is enabled.
- Sits between the host/programming interface and the execution core. The core's pc feeds back to fetch the instruction.

---
 rtl/ppwm_pkg.sv | 13 +
 rtl/ppwm_seq_ctrl_if.sv | 29 ++
 rtl/ppwm_imem.sv | 33 +++
 rtl/ppwm_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_ppwm_seq_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ppwm_pkg.sv
// Shared types and constants for the PWM sequencer/controller.
package ppwm_pkg;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2
  } ctrl_state_e;

  // Wide all-zero NOP; users slice it down to their instruction width.
  localparam logic [63:0] INSTR_NOP = 64'h0;

endpackage

// File: rtl/ppwm_seq_ctrl_if.sv
// Program-load handshake between the host and the sequencer.
interface ppwm_seq_ctrl_if #(
  parameter int unsigned PC_WIDTH    = 4,
  parameter int unsigned INSTR_WIDTH = 7
);

  logic                   prog_valid_i;
  logic                   prog_ready_o;
  logic [PC_WIDTH-1:0]    prog_addr_i;
  logic [INSTR_WIDTH-1:0] prog_data_i;
  logic                   prog_last_i;

  modport master (
    output prog_valid_i,
    output prog_addr_i,
    output prog_data_i,
    output prog_last_i,
    input  prog_ready_o
  );

  modport slave (
    input  prog_valid_i,
    input  prog_addr_i,
    input  prog_data_i,
    input  prog_last_i,
    output prog_ready_o
  );

endinterface

// File: rtl/ppwm_imem.sv
// Instruction store: flop array with async clear, one sync write port, one comb read port.
module ppwm_imem
  import ppwm_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 4,
  parameter int unsigned INSTR_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [PC_WIDTH-1:0]    waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [PC_WIDTH-1:0]    raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 2 ** PC_WIDTH;

  logic [INSTR_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= INSTR_NOP[INSTR_WIDTH-1:0];
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ppwm_seq_ctrl.sv
// Sequencer for one PWM core: program store, prescaled global counter,
// period-start pulse and gating of the core's synchronous reset.
module ppwm_seq_ctrl
  import ppwm_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH    = 7,
  parameter int unsigned PC_WIDTH       = 4,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      reload_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  ppwm_seq_ctrl_if.slave            prog,
  input  logic [PC_WIDTH-1:0]       pc_i,
  output logic [INSTR_WIDTH-1:0]    instr_o,
  output logic                      start_o,
  output logic [COUNTER_WIDTH-1:0]  global_counter_o,
  output logic                      exec_rst_no
);

  ctrl_state_e               state_q;
  logic                      prog_ready_q;
  logic                      exec_rst_nq;
  logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [COUNTER_WIDTH-1:0]  counter_q, counter_d;
  logic [INSTR_WIDTH-1:0]    rdata;
  logic                      prog_write;
  logic                      stay_run;
  logic                      tick;

  assign prog_write = prog.prog_valid_i & prog_ready_q;

  // Controller FSM; ready and core reset are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLoad;
      prog_ready_q <= 1'b1;
      exec_rst_nq  <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (prog_write && prog.prog_last_i) begin
            state_q      <= StArm;
            prog_ready_q <= 1'b0;
          end
        end
        StArm: begin
          if (reload_i) begin
            state_q      <= StLoad;
            prog_ready_q <= 1'b1;
          end else if (en_i) begin
            state_q     <= StRun;
            exec_rst_nq <= 1'b1;
          end
        end
        StRun: begin
          if (reload_i) begin
            state_q      <= StLoad;
            prog_ready_q <= 1'b1;
            exec_rst_nq  <= 1'b0;
          end else if (!en_i) begin
            state_q     <= StArm;
            exec_rst_nq <= 1'b0;
          end
        end
        default: begin
          state_q      <= StLoad;
          prog_ready_q <= 1'b1;
          exec_rst_nq  <= 1'b0;
        end
      endcase
    end
  end

  // Counters only advance while the next cycle is still a run cycle, so every
  // entry into StRun begins at zero and raises start_o immediately.
  assign stay_run = (state_q == StRun) && !reload_i && en_i;
  assign tick     = prescaler_q >= prescale_i;

  always_comb begin
    prescaler_d = '0;
    counter_d   = '0;
    if (stay_run) begin
      if (tick) begin
        prescaler_d = '0;
        counter_d   = counter_q + COUNTER_WIDTH'(1);
      end else begin
        prescaler_d = prescaler_q + PRESCALE_WIDTH'(1);
        counter_d   = counter_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q <= '0;
      counter_q   <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      counter_q   <= counter_d;
    end
  end

  ppwm_imem #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (prog_write),
    .waddr (prog.prog_addr_i),
    .wdata (prog.prog_data_i),
    .raddr (pc_i),
    .rdata (rdata)
  );

  assign prog.prog_ready_o = prog_ready_q;
  assign exec_rst_no       = exec_rst_nq;
  assign global_counter_o  = counter_q;
  assign start_o           = (state_q == StRun) && (counter_q == '0) && (prescaler_q == '0);
  assign instr_o           = (state_q == StRun) ? rdata : INSTR_NOP[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_ppwm_seq_ctrl.sv
// Self-checking bench for ppwm_seq_ctrl: vector table plus scoreboarded sequences.
module tb_ppwm_seq_ctrl;

  localparam int unsigned C_RDY  = 1;
  localparam int unsigned C_RSTN = 2;
  localparam int unsigned C_INS  = 4;
  localparam int unsigned C_ST   = 8;
  localparam int unsigned C_CNT  = 16;
  localparam int unsigned C_ALL  = 31;

  typedef struct {
    logic       ready;
    logic       rstn;
    logic [6:0] instr;
    logic       start;
    logic [7:0] cnt;
    logic [4:0] care;
    string      tag;
  } exp_t;

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic [6:0] d;
    logic       l;
    logic       e;
    logic [3:0] pc;
    logic       ready;
    logic       rstn;
    logic [6:0] instr;
    logic       start;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       reload = 1'b0;
  logic [7:0] prescale = 8'd0;
  logic [3:0] pc = 4'd0;
  logic [6:0] instr;
  logic       start;
  logic [7:0] gcnt;
  logic       exec_rst_n;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[9];

  ppwm_seq_ctrl_if #(.PC_WIDTH(4), .INSTR_WIDTH(7)) pif ();

  ppwm_seq_ctrl #(
    .COUNTER_WIDTH  (8),
    .INSTR_WIDTH    (7),
    .PC_WIDTH       (4),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en_i             (en),
    .reload_i         (reload),
    .prescale_i       (prescale),
    .prog             (pif),
    .pc_i             (pc),
    .instr_o          (instr),
    .start_o          (start),
    .global_counter_o (gcnt),
    .exec_rst_no      (exec_rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, want %0h", tag, field, act, want);
    end
  endtask

  function automatic exp_t mk(input logic rdy, input logic rstn, input logic [6:0] ins,
                              input logic st, input logic [7:0] cnt, input int unsigned care,
                              input string tag);
    exp_t x;
    x.ready = rdy;
    x.rstn  = rstn;
    x.instr = ins;
    x.start = st;
    x.cnt   = cnt;
    x.care  = 5'(care);
    x.tag   = tag;
    return x;
  endfunction

  // Drive one cycle of stimulus and queue what the outputs must show in that cycle.
  task automatic drive(input logic v, input logic [3:0] a, input logic [6:0] d, input logic l,
                       input logic e, input logic r, input logic [7:0] ps, input logic [3:0] p,
                       input exp_t x);
    @(posedge clk);
    #1;
    pif.prog_valid_i = v;
    pif.prog_addr_i  = a;
    pif.prog_data_i  = d;
    pif.prog_last_i  = l;
    en               = e;
    reload           = r;
    prescale         = ps;
    pc               = p;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.care[0]) chk(mon_e.tag, "ready", 32'(pif.prog_ready_o), 32'(mon_e.ready));
      if (mon_e.care[1]) chk(mon_e.tag, "exec_rst_n", 32'(exec_rst_n), 32'(mon_e.rstn));
      if (mon_e.care[2]) chk(mon_e.tag, "instr", 32'(instr), 32'(mon_e.instr));
      if (mon_e.care[3]) chk(mon_e.tag, "start", 32'(start), 32'(mon_e.start));
      if (mon_e.care[4]) chk(mon_e.tag, "counter", 32'(gcnt), 32'(mon_e.cnt));
    end
  end

  initial begin
    pif.prog_valid_i = 1'b0;
    pif.prog_addr_i  = '0;
    pif.prog_data_i  = '0;
    pif.prog_last_i  = 1'b0;

    //            v  a     d      l  e  pc    rdy rstn instr  st cnt
    tbl[0] = '{1'b1, 4'd0, 7'h11, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 7'h00, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 4'd1, 7'h22, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 7'h00, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 4'd2, 7'h05, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 7'h00, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 4'd0, 7'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 7'h00, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 4'd0, 7'h00, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 7'h22, 1'b1, 8'd0};
    tbl[5] = '{1'b0, 4'd0, 7'h00, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 7'h00, 1'b0, 8'd1};
    tbl[6] = '{1'b0, 4'd0, 7'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 7'h11, 1'b0, 8'd2};
    tbl[7] = '{1'b1, 4'd1, 7'h7f, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 7'h05, 1'b0, 8'd3};
    tbl[8] = '{1'b0, 4'd0, 7'h00, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 7'h22, 1'b0, 8'd4};

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 7'h00, 0, 0, C_ALL, "reset"));

    // Load, arm, run with zero-latency fetch; a write during run is ignored
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].l, tbl[i].e, 0, 0, tbl[i].pc,
            mk(tbl[i].ready, tbl[i].rstn, tbl[i].instr, tbl[i].start, tbl[i].cnt, C_ALL,
               $sformatf("tbl%0d", i)));
    end

    // prescale 0: back through arm, then one full 256-cycle period
    drive(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 8'd5, C_RSTN | C_CNT, "run_exit"));
    drive(0, 0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 8'd0, C_RDY | C_RSTN | C_ST | C_CNT, "arm0"));
    for (int i = 0; i <= 256; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0,
            mk(0, 1, 0, (i % 256) == 0, 8'(i % 256), C_RSTN | C_ST | C_CNT,
               $sformatf("ps0_%0d", i)));
    end

    // prescale 3: tick every 4 cycles, start every 1024
    drive(0, 0, 0, 0, 0, 0, 8'd3, 0, mk(0, 1, 0, 0, 8'd1, C_RSTN | C_CNT, "run_exit3"));
    drive(0, 0, 0, 0, 1, 0, 8'd3, 0, mk(0, 0, 0, 0, 8'd0, C_RSTN | C_ST | C_CNT, "arm3"));
    for (int j = 0; j <= 1024; j++) begin
      drive(0, 0, 0, 0, 1, 0, 8'd3, 0,
            mk(0, 1, 0, (j % 1024) == 0, 8'((j / 4) % 256), C_ST | C_CNT,
               $sformatf("ps3_%0d", j)));
    end
    // Lower prescale while the prescaler sits at 2: tick on the next edge
    drive(0, 0, 0, 0, 1, 0, 8'd3, 0, mk(0, 1, 0, 0, 8'd0, C_CNT, "lower_a"));
    drive(0, 0, 0, 0, 1, 0, 8'd0, 0, mk(0, 1, 0, 0, 8'd0, C_CNT, "lower_b"));
    drive(0, 0, 0, 0, 1, 0, 8'd0, 0, mk(0, 1, 0, 0, 8'd1, C_ST | C_CNT, "lower_c"));
    drive(0, 0, 0, 0, 1, 0, 8'd0, 0, mk(0, 1, 0, 0, 8'd2, C_CNT, "lower_d"));

    // Reload mid-run, partial rewrite, contents of other words survive
    drive(0, 0, 0, 0, 1, 1, 0, 0, mk(0, 1, 0, 0, 8'd3, C_RSTN | C_CNT, "reload"));
    drive(0, 0, 0, 1, 1, 0, 0, 0, mk(1, 0, 7'h00, 0, 8'd0, C_ALL, "load_again"));
    drive(1, 0, 7'h33, 1, 0, 0, 0, 0, mk(1, 0, 7'h00, 0, 8'd0, C_ALL, "last_no_valid"));
    drive(0, 0, 0, 0, 1, 0, 0, 0, mk(0, 0, 7'h00, 0, 8'd0, C_ALL, "arm_again"));
    drive(0, 0, 0, 0, 1, 0, 0, 4'd0, mk(0, 1, 7'h33, 1, 8'd0, C_ALL, "new_a0"));
    drive(0, 0, 0, 0, 1, 0, 0, 4'd1, mk(0, 1, 7'h22, 0, 8'd1, C_ALL, "kept_a1"));
    drive(0, 0, 0, 0, 1, 0, 0, 4'd2, mk(0, 1, 7'h05, 0, 8'd2, C_ALL, "kept_a2"));

    // Async reset mid-cycle during run with a simultaneous write
    @(posedge clk);
    #1;
    pif.prog_valid_i = 1'b1;
    pif.prog_addr_i  = 4'd3;
    pif.prog_data_i  = 7'h7f;
    pif.prog_last_i  = 1'b1;
    en               = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst", "ready", 32'(pif.prog_ready_o), 32'd1);
    chk("async_rst", "exec_rst_n", 32'(exec_rst_n), 32'd0);
    chk("async_rst", "start", 32'(start), 32'd0);
    chk("async_rst", "counter", 32'(gcnt), 32'd0);
    chk("async_rst", "instr", 32'(instr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst              = 1'b0;
    pif.prog_valid_i = 1'b0;
    drive(1, 4'd5, 7'h00, 1, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, C_RDY | C_RSTN, "post_rst_load"));
    drive(0, 0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, C_RDY | C_RSTN, "post_rst_arm"));
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 4'(k), mk(0, 1, 7'h00, 0, 0, C_RSTN | C_INS,
            $sformatf("cleared%0d", k)));
    end

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
